limit_counter: RTL and testbench



---
 rtl/limit_counter.sv | 88 ++++++++
 tb/tb_limit_counter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/limit_counter.sv
// Enable-gated cycle counter: counts 0..limit after a start request, flags busy and pulses done.
// Optional macro LIMIT_COUNTER_AUTORESTART_EN lets DONE restart straight into a new job.
module limit_counter (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic        clear_i,
    input  logic [15:0] limit_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] count_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] limit_q, limit_d;
    logic [15:0] count_inc;

    assign count_inc = count_q + 16'd1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            count_q <= '0;
            limit_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        if (clear_i) begin
            state_d = IDLE;
            count_d = '0;
            limit_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (en_i) begin
                        // A zero limit is latched too, so count_o == limit_q holds in DONE.
                        limit_d = limit_i;
                        count_d = '0;
                        state_d = (limit_i != 16'd0) ? BUSY : DONE;
                    end
                end
                BUSY: begin
                    if (en_i) begin
                        count_d = count_inc;
                        if (count_inc == limit_q) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
`ifdef LIMIT_COUNTER_AUTORESTART_EN
                    if (en_i && (limit_i != 16'd0)) begin
                        limit_d = limit_i;
                        count_d = '0;
                        state_d = BUSY;
                    end
`endif
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                    limit_d = '0;
                end
            endcase
        end
    end

    assign busy_o  = (state_q == BUSY);
    assign done_o  = (state_q == DONE);
    assign count_o = count_q;

endmodule

// File: tb/tb_limit_counter.sv
// Randomised and directed bench for limit_counter against a job-level reference model.
module tb_limit_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        clear;
    logic [15:0] limit;
    logic        busy;
    logic        done;
    logic [15:0] count;

    int checks = 0;
    int errors = 0;

    // Reference: a job is either running, just finished, or absent.
    bit          m_running;
    bit          m_finished;
    logic [15:0] m_elapsed;
    logic [15:0] m_target;

    limit_counter dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .en_i    (en),
        .clear_i (clear),
        .limit_i (limit),
        .busy_o  (busy),
        .done_o  (done),
        .count_o (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_running  = 1'b0;
        m_finished = 1'b0;
        m_elapsed  = 16'd0;
        m_target   = 16'd0;
    endtask

    task automatic model_start();
        m_target  = limit;
        m_elapsed = 16'd0;
        if (limit == 16'd0) m_finished = 1'b1;
        else                m_running  = 1'b1;
    endtask

    task automatic model_edge();
        if (clear) begin
            model_reset();
        end else if (m_finished) begin
            m_finished = 1'b0;
`ifdef LIMIT_COUNTER_AUTORESTART_EN
            if (en && limit != 16'd0) model_start();
`endif
        end else if (m_running) begin
            if (en) begin
                m_elapsed = m_elapsed + 16'd1;
                if (m_elapsed == m_target) begin
                    m_running  = 1'b0;
                    m_finished = 1'b1;
                end
            end
        end else if (en) begin
            model_start();
        end
    endtask

    task automatic check_outputs();
        check_eq("busy", {31'd0, busy}, {31'd0, m_running});
        check_eq("done", {31'd0, done}, {31'd0, m_finished});
        check_eq("count", {16'd0, count}, {16'd0, m_elapsed});
        check_eq("busy_and_done", {31'd0, busy & done}, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        rst_n = 1'b1;
        en    = 1'b0;
        clear = 1'b0;
        limit = 16'd0;
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_done", {31'd0, done}, 32'd0);
        check_eq("reset_count", {16'd0, count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Basic job, limit 5
        limit = 16'd5; en = 1'b1;
        step();
        check_eq("basic_start_busy", {31'd0, busy}, 32'd1);
        check_eq("basic_start_count", {16'd0, count}, 32'd0);
        for (int i = 0; i < 5; i++) step();
        check_eq("basic_end_busy", {31'd0, busy}, 32'd0);
        check_eq("basic_end_done", {31'd0, done}, 32'd1);
        check_eq("basic_end_count", {16'd0, count}, 32'd5);
        en = 1'b0;
        step();
        check_eq("basic_done_pulse", {31'd0, done}, 32'd0);

        // Pause and resume, limit 10
        limit = 16'd10; en = 1'b1;
        step(); step(); step();
        check_eq("pause_pre_count", {16'd0, count}, 32'd2);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("pause_hold_count", {16'd0, count}, 32'd2);
            check_eq("pause_hold_busy", {31'd0, busy}, 32'd1);
        end
        en = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check_eq("resume_done", {31'd0, done}, 32'd1);
        check_eq("resume_count", {16'd0, count}, 32'd10);
        en = 1'b0;
        step();

        // Clear mid-job with enable still high
        limit = 16'd20; en = 1'b1;
        step(); step();
        check_eq("clear_pre_count", {16'd0, count}, 32'd1);
        clear = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("clear_busy", {31'd0, busy}, 32'd0);
            check_eq("clear_done", {31'd0, done}, 32'd0);
            check_eq("clear_count", {16'd0, count}, 32'd0);
        end
        clear = 1'b0; en = 1'b0;
        step();

        // Zero limit
        limit = 16'd0; en = 1'b1;
        step();
        check_eq("zero_done", {31'd0, done}, 32'd1);
        check_eq("zero_busy", {31'd0, busy}, 32'd0);
        check_eq("zero_count", {16'd0, count}, 32'd0);
        en = 1'b0;
        step();
        check_eq("zero_done_pulse", {31'd0, done}, 32'd0);

        // Asynchronous reset mid-job
        limit = 16'd100; en = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check_eq("rst_pre_count", {16'd0, count}, 32'd5);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_async_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_async_done", {31'd0, done}, 32'd0);
        check_eq("rst_async_count", {16'd0, count}, 32'd0);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1; en = 1'b0;
        step();

        // Maximum limit runs to completion without wrap
        limit = 16'hFFFF; en = 1'b1;
        step();
        for (int i = 0; i < 5; i++) step();
        check_eq("max_count5", {16'd0, count}, 32'd5);
        check_eq("max_busy5", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 65530; i++) step();
        check_eq("max_done", {31'd0, done}, 32'd1);
        check_eq("max_count", {16'd0, count}, 32'h0000FFFF);
        en = 1'b0;
        step();

`ifdef LIMIT_COUNTER_AUTORESTART_EN
        limit = 16'd5; en = 1'b1;
        step();
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 5; i++) step();
            check_eq("auto_done", {31'd0, done}, 32'd1);
            step();
            check_eq("auto_restart_busy", {31'd0, busy}, 32'd1);
            check_eq("auto_restart_done", {31'd0, done}, 32'd0);
            check_eq("auto_restart_count", {16'd0, count}, 32'd0);
        end
        en = 1'b0;
        step(); step();
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            en    = ($urandom_range(0, 9) < 8);
            clear = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0)
                limit = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
